// File: rtl/timer_arb_pkg.sv
// Shared definitions for the timer arbiter: FSM state encoding and default sizing.
// The optional build macro TIMER_ARB_FIXED_PRIO_EN is consumed by timer_arbiter.
package timer_arb_pkg;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_CNT_WIDTH = 8;
   localparam int DEF_IDX_W     = $clog2(DEF_NUM_REQ);
endpackage

// File: rtl/interval_counter.sv
// Shared down-counter: clear beats load beats decrement, and the count holds at zero.
module interval_counter
   import timer_arb_pkg::*;
#(
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] load_val,
   input  logic                 en,
   input  logic                 clear,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 zero
);

   assign zero = (count == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && !zero) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin sharing of one interval timer among NUM_REQ requesters.
// Define TIMER_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, pointer held at 0).
module timer_arbiter
   import timer_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*CNT_WIDTH-1:0]   dur,
   output logic [NUM_REQ-1:0]             grant,
   output logic [NUM_REQ-1:0]             done,
   output logic                           busy,
   output logic [CNT_WIDTH-1:0]           count_out
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [1:0]       state;
   logic [IDX_W-1:0] w;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_adv;
   logic [IDX_W-1:0] win_idx;
   logic             win_vld;
   logic [NUM_REQ-1:0] w_onehot;
   logic             cnt_zero;
   logic             aborting;

   function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
      int s;
      s = (base + off) % NUM_REQ;
      return s[IDX_W-1:0];
   endfunction

   // Scan downward in offset so the smallest offset from the pointer wins.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[wrap_idx(int'(ptr), k)]) begin
            win_vld = 1'b1;
            win_idx = wrap_idx(int'(ptr), k);
         end
      end
   end

`ifdef TIMER_ARB_FIXED_PRIO_EN
   assign ptr_adv = '0;
`else
   assign ptr_adv = (w == IDX_W'(NUM_REQ - 1)) ? '0 : w + 1'b1;
`endif

   assign aborting = (state == RUN) && !req[w];
   assign w_onehot = NUM_REQ'(1) << w;
   assign grant    = (state != IDLE) ? w_onehot : '0;
   assign done     = (state == DONE) ? w_onehot : '0;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         w     <= '0;
         ptr   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  w     <= win_idx;
                  state <= RUN;
               end
            end
            RUN: begin
               if (aborting) begin
                  state <= IDLE;
                  ptr   <= ptr_adv;
               end else if (cnt_zero) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
               ptr   <= ptr_adv;
            end
            default: state <= IDLE;
         endcase
      end
   end

   interval_counter #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_counter (
      .clk      (clk),
      .reset    (reset),
      .load     ((state == IDLE) && win_vld),
      .load_val (dur[int'(win_idx)*CNT_WIDTH +: CNT_WIDTH]),
      .en       ((state == RUN) && !aborting),
      .clear    (aborting),
      .count    (count_out),
      .zero     (cnt_zero)
   );

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed self-checking bench for timer_arbiter (NUM_REQ=4, CNT_WIDTH=8).
// Build with TIMER_ARB_FIXED_PRIO_EN to exercise the fixed-priority variant.
module tb_timer_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] dur;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        busy;
   logic [7:0]  count_out;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   timer_arbiter #(.NUM_REQ(4), .CNT_WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .dur       (dur),
      .grant     (grant),
      .done      (done),
      .busy      (busy),
      .count_out (count_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req   = '0;
      dur   = '0;
      #3;
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
      checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done got=%b exp=0000", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (count_out !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_out); end
      #7;
      reset = 1'b0;
      step();
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL idle_grant got=%b exp=0000", grant); end
   endtask

   task automatic test_single();
      req = 4'b0001;
      dur = {8'd0, 8'd0, 8'd0, 8'd3};
      for (int i = 3; i >= 0; i--) begin
         step();
         checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL single_grant c=%0d got=%b exp=0001", i, grant); end
         checks++; if (count_out !== 8'(i)) begin failures++; $display("FAIL single_count got=%0d exp=%0d", count_out, i); end
         checks++; if (done !== 4'b0000) begin failures++; $display("FAIL single_early_done got=%b exp=0000", done); end
      end
      step();
      checks++; if (done !== 4'b0001) begin failures++; $display("FAIL single_done got=%b exp=0001", done); end
      checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL single_done_grant got=%b/%b exp=0001/1", grant, busy); end
      req = 4'b0000;
      step();
      checks++; if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL single_release got=%b/%b/%b exp=0000/0000/0", grant, done, busy); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g [5];
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
      exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
      pulse_reset();
      req = 4'b1111;
      dur = '0;
      for (int g = 0; g < 5; g++) begin
         step();
         checks++; if (grant !== exp_g[g] || done !== 4'b0000) begin failures++; $display("FAIL rr_run g=%0d got=%b/%b exp=%b/0000", g, grant, done, exp_g[g]); end
         step();
         checks++; if (grant !== exp_g[g] || done !== exp_g[g]) begin failures++; $display("FAIL rr_done g=%0d got=%b/%b exp=%b/%b", g, grant, done, exp_g[g], exp_g[g]); end
         step();
         checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL rr_idle g=%0d got=%b/%b exp=0000/0", g, grant, busy); end
      end
      req = 4'b0000;
      step();
   endtask

   task automatic test_abort();
      pulse_reset();
      req = 4'b0100;
      dur = {8'd0, 8'd5, 8'd0, 8'd0};
      step();
      checks++; if (grant !== 4'b0100 || count_out !== 8'd5) begin failures++; $display("FAIL abort_start got=%b/%0d exp=0100/5", grant, count_out); end
      step();
      step();
      checks++; if (count_out !== 8'd3) begin failures++; $display("FAIL abort_count got=%0d exp=3", count_out); end
      dur = {8'd0, 8'd9, 8'd0, 8'd0};
      req = 4'b0000;
      step();
      checks++; if (grant !== 4'b0000 || count_out !== 8'd0 || done !== 4'b0000) begin failures++; $display("FAIL abort_stop got=%b/%0d/%b exp=0000/0/0000", grant, count_out, done); end
      step();
      checks++; if (done !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b/%b exp=0000/0", done, busy); end
      req = 4'b0101;
      dur = {8'd0, 8'd0, 8'd0, 8'd2};
      step();
      checks++; if (grant !== 4'b0001 || count_out !== 8'd2) begin failures++; $display("FAIL abort_wrap got=%b/%0d exp=0001/2", grant, count_out); end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_reset_mid_run();
      req = 4'b0010;
      dur = {8'd0, 8'd0, 8'd4, 8'd0};
      step();
      step();
      step();
      checks++; if (count_out !== 8'd2 || grant !== 4'b0010) begin failures++; $display("FAIL midrst_pre got=%0d/%b exp=2/0010", count_out, grant); end
      reset = 1'b1;
      #1;
      checks++; if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || count_out !== 8'd0) begin failures++; $display("FAIL midrst_async got=%b/%b/%b/%0d exp=0000/0000/0/0", grant, done, busy, count_out); end
      req = 4'b0011;
      dur = {8'd0, 8'd0, 8'd1, 8'd1};
      #1;
      reset = 1'b0;
      step();
      checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL midrst_ptr got=%b exp=0001", grant); end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_long();
      int run;
      req = 4'b0010;
      dur = {8'd0, 8'd0, 8'hFF, 8'd0};
      run = 0;
      step();
      while (done === 4'b0000 && run < 300) begin
         if (grant !== 4'b0010 || count_out !== 8'(255 - run)) begin
            checks++; failures++;
            $display("FAIL long_count run=%0d got=%b/%0d exp=0010/%0d", run, grant, count_out, 255 - run);
         end
         run++;
         step();
      end
      checks++; if (run !== 256) begin failures++; $display("FAIL long_run_cycles got=%0d exp=256", run); end
      checks++; if (done !== 4'b0010 || count_out !== 8'd0) begin failures++; $display("FAIL long_done got=%b/%0d exp=0010/0", done, count_out); end
      req = 4'b0000;
      step();
      checks++; if (count_out !== 8'd0 || grant !== 4'b0000) begin failures++; $display("FAIL long_no_wrap got=%0d/%b exp=0/0000", count_out, grant); end
   endtask

   task automatic test_fixed_prio();
      pulse_reset();
      req = 4'b0110;
      dur = {8'd1, 8'd1, 8'd1, 8'd1};
      for (int g = 0; g < 3; g++) begin
         step();
         checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL fixed_grant g=%0d got=%b exp=0010", g, grant); end
         step();
         step();
         checks++; if (done !== 4'b0010) begin failures++; $display("FAIL fixed_done g=%0d got=%b exp=0010", g, done); end
         step();
         checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL fixed_idle g=%0d got=%b exp=0000", g, grant); end
      end
      req = 4'b0000;
      step();
   endtask

   initial begin
      test_reset();
      test_single();
`ifdef TIMER_ARB_FIXED_PRIO_EN
      test_fixed_prio();
`else
      test_round_robin();
      test_abort();
`endif
      test_reset_mid_run();
      test_long();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one down-counting interval timer among NUM_REQ requesters.
- Round-robin arbitration picks a requester and loads its requested duration into the shared counter.
- The winner keeps the grant while the counter runs down, then receives a one-cycle done pulse.
- Sits between the lab's counter datapath and the blocks that need timed intervals: debouncers, blink generators, delay sequencers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_WIDTH, 8, width of the shared counter and of each duration field.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req  input  NUM_REQ  per-requester request level; held high until done or abort.
- dur  input  NUM_REQ*CNT_WIDTH  packed durations; requester i uses bits [i*CNT_WIDTH +: CNT_WIDTH].
- grant  output  NUM_REQ  one-hot grant, or all-zero.
- done  output  NUM_REQ  one-cycle completion pulse to the current grantee.
- busy  output  1  high in RUN and DONE.
- count_out  output  CNT_WIDTH  live shared counter value.

Behaviour:
- Reset: state=IDLE, grant=0, done=0, busy=0, count_out=0, rr pointer=0. All take effect asynchronously while reset is high.
- State IDLE:
  - If any req bit is high, the winner w is the first set bit searching from the pointer upward, wrapping modulo NUM_REQ.
  - At that clock edge: latch w, load count_out=dur[w], assert grant[w], go to RUN.
  - Otherwise stay in IDLE.
- State RUN:
  - Each cycle with count_out>0 decrements it by 1.
  - With count_out==0: go to DONE.
  - Effect: grant[w] is high for dur[w]+1 cycles in RUN. dur=0 gives exactly one RUN cycle.
- State DONE (exactly one cycle):
  - done[w]=1, grant[w] still high.
  - Next edge: grant=0, done=0, pointer=(w+1) mod NUM_REQ, go to IDLE.
- Spacing: at least one IDLE cycle between consecutive grants. The minimum grant-to-grant period is dur+3 cycles.
- Duration sampling: dur is sampled only at the arbitration edge. Changes during RUN are ignored.
- Abort: if req[w] is low in any RUN cycle, the next edge goes to IDLE with grant=0, count_out=0, no done pulse, and the pointer advances to w+1.
- Request changes during a grant: new or dropped req on non-granted lines has no effect until IDLE.
- Reset mid-RUN: immediate return to the reset values. The pointer returns to 0.
- Invariants: count_out never wraps below 0 (no underflow). grant and done are never multi-hot.

Optional Feature:
- Macro: TIMER_ARB_FIXED_PRIO_EN.
- When defined: fixed priority, lowest index wins. The pointer is unused and held at 0.
- When undefined: round-robin as above.
- The state machine and timing are identical in both builds.

Decomposition:
- Package timer_arb_pkg holds:
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - localparam IDX_W = $clog2(NUM_REQ) defaults.
- Sub-module interval_counter (load, load_val, en, clear → count, zero flag): the shared datapath counter, instantiated once.
- Arbitration, pointer and state machine stay in timer_arbiter.

Test Plan:
- Reset 10ns, then req=4'b0001, dur0=3 → grant=0001 next edge. count_out 3,2,1,0 on successive cycles. done[0] one cycle after count 0. grant drops the next edge.
- req=4'b1111, all dur=0 → grants in order 0001,0010,0100,1000,0001. Each grant lasts 2 cycles (RUN+DONE) with 1 IDLE cycle between grants.
- req=4'b0100, dur2=5. Drop req[2] while count_out=3 → next edge grant=0, count_out=0, done never pulses. Next request req=4'b0101 is granted to index 0 (pointer=3 wraps to 0).
- Assert reset while in RUN with count_out=2 → grant, done, busy and count_out are 0 within the same timestep, before the next clock edge.
- Build with TIMER_ARB_FIXED_PRIO_EN, req=4'b0110 held, dur=1 → grant=0010 repeatedly; index 2 is never granted.
- dur1=8'hFF, req=4'b0010 → exactly 256 RUN cycles, then done[1]. count_out never wraps past 0.
